// File: rtl/btn_src_arbiter.sv
// Merges debounced physical buttons and UART command bytes into one-hot button pulses,
// with source-ownership lockout and a two-byte mode-select parser. Optional: BTN_LOWERCASE_EN.
module btn_src_arbiter #(
  parameter int LOCK_CYCLES = 8,
  parameter int TMO_CYCLES  = 16,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_btn,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [3:0] o_btn,
  output logic [1:0] o_mode,
  output logic [1:0] o_owner,
  output logic       o_drop
);

  typedef enum logic {P_IDLE, P_PREFIX} parse_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_PHYS = 2'b01,
    OWN_UART = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    MODE_WATCH     = 2'b00,
    MODE_STOPWATCH = 2'b01,
    MODE_SENSOR    = 2'b10
  } mode_t;

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TMO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_T    = 8'h54;

  // Letter match; with lowercase enabled, bit 5 distinguishes the two cases in ASCII.
  function automatic logic byte_is(input logic [7:0] b, input logic [7:0] ch);
`ifdef BTN_LOWERCASE_EN
    return (b == ch) || (b == (ch | 8'h20));
`else
    return b == ch;
`endif
  endfunction

  function automatic mode_t mode_step(input mode_t m);
    case (m)
      MODE_WATCH:     return MODE_STOPWATCH;
      MODE_STOPWATCH: return MODE_SENSOR;
      default:        return MODE_WATCH;
    endcase
  endfunction

  parse_state_t     state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  owner_t           owner_q, owner_d;
  mode_t            mode_q, mode_d;
  logic [3:0]       btn_q, btn_d;
  logic             drop_q, drop_d;

  logic [3:0] phys_btn;
  logic       phys_req;
  logic [3:0] uart_btn;
  logic       uart_req;

  // Physical request: several simultaneous bits collapse by U>D>L>R priority.
  assign phys_req = |i_btn;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    phys_btn = 4'b0000;
    if (i_btn[3])      phys_btn = 4'b1000;
    else if (i_btn[2]) phys_btn = 4'b0100;
    else if (i_btn[1]) phys_btn = 4'b0010;
    else if (i_btn[0]) phys_btn = 4'b0001;
  end

  // Parser: button bytes and 'M' only act in P_IDLE; '#' opens a timed prefix window.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    mode_d   = mode_q;
    uart_req = 1'b0;
    uart_btn = 4'b0000;

    case (state_q)
      P_IDLE: begin
        if (i_rx_done) begin
          if (byte_is(i_rx_data, CH_U)) begin
            uart_req = 1'b1;
            uart_btn = 4'b1000;
          end else if (byte_is(i_rx_data, CH_D)) begin
            uart_req = 1'b1;
            uart_btn = 4'b0100;
          end else if (byte_is(i_rx_data, CH_L)) begin
            uart_req = 1'b1;
            uart_btn = 4'b0010;
          end else if (byte_is(i_rx_data, CH_R)) begin
            uart_req = 1'b1;
            uart_btn = 4'b0001;
          end else if (byte_is(i_rx_data, CH_M)) begin
            mode_d = mode_step(mode_q);
          end else if (i_rx_data == CH_HASH) begin
            state_d = P_PREFIX;
            tmo_d   = TMO_LOAD;
          end
        end
      end

      P_PREFIX: begin
        if (i_rx_done) begin
          // A byte on the expiry cycle still wins over the timeout.
          state_d = P_IDLE;
          tmo_d   = CNT_ZERO;
          if (byte_is(i_rx_data, CH_W))      mode_d = MODE_WATCH;
          else if (byte_is(i_rx_data, CH_S)) mode_d = MODE_STOPWATCH;
          else if (byte_is(i_rx_data, CH_T)) mode_d = MODE_SENSOR;
        end else if (tmo_q <= CNT_ONE) begin
          state_d = P_IDLE;
          tmo_d   = CNT_ZERO;
        end else begin
          tmo_d = tmo_q - CNT_ONE;
        end
      end

      default: begin
        state_d = P_IDLE;
        tmo_d   = CNT_ZERO;
      end
    endcase
  end

  // Arbitration is judged against the owner currently shown, even on the expiry cycle.
  always_comb begin
    owner_d = owner_q;
    lock_d  = lock_q;
    btn_d   = 4'b0000;
    drop_d  = 1'b0;

    if (lock_q != CNT_ZERO) begin
      lock_d = lock_q - CNT_ONE;
      if (lock_q == CNT_ONE) owner_d = OWN_NONE;
    end

    case (owner_q)
      OWN_NONE: begin
        if (phys_req) begin
          btn_d   = phys_btn;
          owner_d = OWN_PHYS;
          lock_d  = LOCK_LOAD;
          drop_d  = uart_req;
        end else if (uart_req) begin
          btn_d   = uart_btn;
          owner_d = OWN_UART;
          lock_d  = LOCK_LOAD;
        end
      end

      OWN_PHYS: begin
        if (phys_req) begin
          btn_d   = phys_btn;
          owner_d = OWN_PHYS;
          lock_d  = LOCK_LOAD;
        end
        if (uart_req) drop_d = 1'b1;
      end

      OWN_UART: begin
        if (uart_req) begin
          btn_d   = uart_btn;
          owner_d = OWN_UART;
          lock_d  = LOCK_LOAD;
        end
        if (phys_req) drop_d = 1'b1;
      end

      default: begin
        owner_d = OWN_NONE;
        lock_d  = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      tmo_q   <= CNT_ZERO;
      lock_q  <= CNT_ZERO;
      owner_q <= OWN_NONE;
      mode_q  <= MODE_WATCH;
      btn_q   <= 4'b0000;
      drop_q  <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
      btn_q   <= btn_d;
      drop_q  <= drop_d;
    end
  end

  assign o_btn   = btn_q;
  assign o_mode  = mode_q;
  assign o_owner = owner_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_btn_src_arbiter.sv
// Self-checking bench for btn_src_arbiter: cycle-count-based reference model compared on
// every falling edge, plus directed literal checks that pin the model.
module tb_btn_src_arbiter;

  localparam int LOCK = 8;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i_btn = 4'b0000;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic [3:0] o_btn;
  logic [1:0] o_mode;
  logic [1:0] o_owner;
  logic       o_drop;

  btn_src_arbiter #(.LOCK_CYCLES(LOCK), .TMO_CYCLES(TMO), .CNT_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (i_btn),
    .i_rx_data (i_rx_data),
    .i_rx_done (i_rx_done),
    .o_btn     (o_btn),
    .o_mode    (o_mode),
    .o_owner   (o_owner),
    .o_drop    (o_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership and prefix windows tracked as absolute edge numbers.
  int         cyc;
  int         own_until;
  int         own_src;
  int         pref_edge;
  bit         pending;
  int         m_mode;
  logic [3:0] exp_btn;
  logic [1:0] exp_owner;
  logic [1:0] exp_mode;
  logic       exp_drop;

  function automatic logic [7:0] norm(input logic [7:0] b);
`ifdef BTN_LOWERCASE_EN
    if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
`endif
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; own_until = 0; own_src = 0; pref_edge = 0; pending = 0; m_mode = 0;
      exp_btn = 4'b0000; exp_owner = 2'b00; exp_mode = 2'b00; exp_drop = 1'b0;
    end else begin
      int         e, cur, src;
      bit         preq, ureq, acc;
      logic [3:0] pb, ub;
      logic [7:0] b;
      e    = cyc + 1;
      cur  = (cyc < own_until) ? own_src : 0;
      preq = (i_btn != 4'b0000);
      pb   = 4'b0000;
      for (int i = 3; i >= 0; i--)
        if (i_btn[i] && pb == 4'b0000) pb = 4'(1 << i);
      ureq = 0; ub = 4'b0000;
      if (i_rx_done) begin
        b = norm(i_rx_data);
        if (pending && (e <= pref_edge + TMO)) begin
          pending = 0;
          if (b == 8'h57) m_mode = 0;
          else if (b == 8'h53) m_mode = 1;
          else if (b == 8'h54) m_mode = 2;
        end else begin
          pending = 0;
          case (b)
            8'h55: begin ureq = 1; ub = 4'b1000; end
            8'h44: begin ureq = 1; ub = 4'b0100; end
            8'h4C: begin ureq = 1; ub = 4'b0010; end
            8'h52: begin ureq = 1; ub = 4'b0001; end
            8'h4D: m_mode = (m_mode + 1) % 3;
            8'h23: begin pending = 1; pref_edge = e; end
            default: ;
          endcase
        end
      end
      exp_btn = 4'b0000; exp_drop = 1'b0; acc = 0; src = 0;
      if (preq && (cur == 0 || cur == 1)) begin
        acc = 1; src = 1; exp_btn = pb; exp_drop = ureq;
      end else if (ureq && (cur == 0 || cur == 2)) begin
        acc = 1; src = 2; exp_btn = ub; exp_drop = preq;
      end else if (preq || ureq) begin
        exp_drop = 1'b1;
      end
      if (acc) begin
        own_src = src; own_until = e + LOCK;
      end
      exp_owner = (e < own_until) ? 2'(own_src) : 2'b00;
      exp_mode  = 2'(m_mode);
      cyc = e;
    end
  end

  always @(negedge clk) begin
    check("cmp_btn",   8'(o_btn),   8'(exp_btn));
    check("cmp_mode",  8'(o_mode),  8'(exp_mode));
    check("cmp_owner", 8'(o_owner), 8'(exp_owner));
    check("cmp_drop",  8'(o_drop),  8'(exp_drop));
  end

  // Each stimulus task returns 1 time unit after the edge that consumed its inputs.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic phys(input logic [3:0] b);
    i_btn = b;
    @(posedge clk); #1;
    i_btn = 4'b0000;
  endtask

  task automatic uart(input logic [7:0] d);
    i_rx_data = d; i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic both(input logic [3:0] b, input logic [7:0] d);
    i_btn = b; i_rx_data = d; i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_btn = 4'b0000; i_rx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(2);
    check("rst_btn",   8'(o_btn),   8'h00);
    check("rst_mode",  8'(o_mode),  8'h00);
    check("rst_owner", 8'(o_owner), 8'h00);
    check("rst_drop",  8'(o_drop),  8'h00);
    rst_n = 1'b1;
    idle(1);

    // Physical press with two bits set: U wins, owner held for LOCK cycles.
    phys(4'b1010);
    check("p1_btn",   8'(o_btn),   8'h08);
    check("p1_owner", 8'(o_owner), 8'h01);
    check("p1_drop",  8'(o_drop),  8'h00);
    idle(LOCK - 1);
    check("p1_owner_last", 8'(o_owner), 8'h01);
    idle(1);
    check("p1_owner_free", 8'(o_owner), 8'h00);

    // Simultaneous sources with no owner: physical wins, UART dropped.
    both(4'b0001, 8'h55);
    check("tie_btn",   8'(o_btn),   8'h01);
    check("tie_drop",  8'(o_drop),  8'h01);
    check("tie_owner", 8'(o_owner), 8'h01);
    idle(1);
    check("tie_drop_end", 8'(o_drop), 8'h00);
    idle(10);

    phys(4'b0110);
    check("prio_dl", 8'(o_btn), 8'h04);
    phys(4'b0011);
    check("prio_lr", 8'(o_btn), 8'h02);
    idle(10);

    // UART owns; physical press during lockout dropped, accepted once free.
    uart(8'h44);
    check("u_d_btn",   8'(o_btn),   8'h04);
    check("u_d_owner", 8'(o_owner), 8'h02);
    idle(2);
    phys(4'b0100);
    check("lock_btn",  8'(o_btn),  8'h00);
    check("lock_drop", 8'(o_drop), 8'h01);
    idle(5);
    check("lock_free", 8'(o_owner), 8'h00);
    phys(4'b0100);
    check("after_btn",   8'(o_btn),   8'h04);
    check("after_owner", 8'(o_owner), 8'h01);
    idle(10);

    // Request on the 1->0 cycle is judged against the still-current owner.
    uart(8'h52);
    check("edge_accept", 8'(o_btn), 8'h01);
    idle(LOCK - 1);
    phys(4'b0001);
    check("edge_btn",   8'(o_btn),   8'h00);
    check("edge_drop",  8'(o_drop),  8'h01);
    check("edge_owner", 8'(o_owner), 8'h00);
    idle(2);

    uart(8'h75);
    check("lower_u", 8'(o_btn), 8'h00);
    idle(10);

    // Mode commands: prefix, timeout, boundary byte, and 'M' cycling.
    uart(8'h23); idle(4); uart(8'h53);
    check("mode_s", 8'(o_mode), 8'h01);
    uart(8'h23); idle(17); uart(8'h54);
    check("tmo_t_mode", 8'(o_mode), 8'h01);
    check("tmo_t_btn",  8'(o_btn),  8'h00);
    uart(8'h4D);
    check("m1", 8'(o_mode), 8'h02);
    uart(8'h4D);
    check("m2", 8'(o_mode), 8'h00);
    uart(8'h23); idle(TMO - 1); uart(8'h54);
    check("tmo_last_ok", 8'(o_mode), 8'h02);
    uart(8'h23); idle(TMO); uart(8'h57);
    check("tmo_expired", 8'(o_mode), 8'h02);
    uart(8'h4D);
    check("m3", 8'(o_mode), 8'h00);

    // Prefix aborted by a button byte; next button byte is a normal press.
    uart(8'h23); uart(8'h55);
    check("abort_btn",  8'(o_btn),  8'h00);
    check("abort_mode", 8'(o_mode), 8'h00);
    check("abort_drop", 8'(o_drop), 8'h00);
    uart(8'h55);
    check("post_abort_btn", 8'(o_btn), 8'h08);

    // Async reset with lock active and prefix pending.
    uart(8'h4D);
    check("pre_rst_mode",  8'(o_mode),  8'h01);
    check("pre_rst_owner", 8'(o_owner), 8'h02);
    uart(8'h23);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_btn",   8'(o_btn),   8'h00);
    check("arst_mode",  8'(o_mode),  8'h00);
    check("arst_owner", 8'(o_owner), 8'h00);
    check("arst_drop",  8'(o_drop),  8'h00);
    idle(2);
    rst_n = 1'b1;
    uart(8'h53);
    check("post_rst_s_mode", 8'(o_mode), 8'h00);
    check("post_rst_s_btn",  8'(o_btn),  8'h00);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
